// File: rtl/onehot_regbank.sv
// rtl/onehot_regbank.sv - four-entry register bank written through a one-hot select
// Two registered read ports with write bypass, sticky illegal-select error, saturating write count.
module onehot_regbank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       wr_sel,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic [1:0]       rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [1:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             sel_err,
    input  logic             err_clr,
    output logic [7:0]       wr_count
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ERROR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [4];
    logic [WIDTH-1:0] mem_d [4];
    logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic [7:0]       wr_count_q, wr_count_d;

    logic sel_onehot;
    logic wr_accept;
    logic wr_legal;

    always_comb begin
        sel_onehot = (wr_sel == 4'b0001) || (wr_sel == 4'b0010) ||
                     (wr_sel == 4'b0100) || (wr_sel == 4'b1000);
        wr_accept  = wr_valid && (state_q == ST_IDLE);
        wr_legal   = wr_accept && sel_onehot;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_legal && wr_sel[i]) begin
                mem_d[i] = wr_data;
            end
        end
        // Reading the next-state array gives write-to-read bypass for free.
        rd_data_a_d = mem_d[rd_addr_a];
        rd_data_b_d = mem_d[rd_addr_b];

        wr_count_d = wr_count_q;
        if (wr_legal && (wr_count_q != 8'hFF)) begin
            wr_count_d = wr_count_q + 8'd1;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_accept && !sel_onehot) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (err_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign wr_ready  = (state_q == ST_IDLE);
    assign sel_err   = (state_q == ST_ERROR);
    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_onehot_regbank.sv
// tb/tb_onehot_regbank.sv - directed self-checking bench for onehot_regbank
module tb_onehot_regbank;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       wr_sel;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic [1:0]       rd_addr_a;
    logic [WIDTH-1:0] rd_data_a;
    logic [1:0]       rd_addr_b;
    logic [WIDTH-1:0] rd_data_b;
    logic             sel_err;
    logic             err_clr;
    logic [7:0]       wr_count;

    int total = 0;
    int bad   = 0;

    onehot_regbank #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_sel    (wr_sel),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .sel_err   (sel_err),
        .err_clr   (err_clr),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_entries(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                                 input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = 2'(i);
            rd_addr_b = 2'(3 - i);
            step();
            chk({tag, "_a"}, rd_data_a, exp[i]);
            chk({tag, "_b"}, rd_data_b, exp[3 - i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wr_sel = 4'b0000; wr_valid = 1'b0; wr_data = '0;
        rd_addr_a = 2'd0; rd_addr_b = 2'd0; err_clr = 1'b0;
        #1;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", wr_ready, 1);
        chk("rst_err", sel_err, 0);
        chk("rst_count", wr_count, 0);
        check_entries("rst_rd", 8'h00, 8'h00, 8'h00, 8'h00);

        // Back-to-back legal writes, one per cycle.
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_sel   = 4'(1 << i);
            wr_data  = 8'hA1 + 8'(i);
            chk("wr_nostall", wr_ready, 1);
            step();
        end
        wr_valid = 1'b0;
        chk("wr_count4", wr_count, 4);
        check_entries("wr_rd", 8'hA1, 8'hA2, 8'hA3, 8'hA4);

        // Bypass: write to entry 2 while port A reads it.
        rd_addr_a = 2'd2; rd_addr_b = 2'd0;
        wr_valid = 1'b1; wr_sel = 4'b0100; wr_data = 8'h5C;
        step();
        wr_valid = 1'b0;
        chk("byp_a", rd_data_a, 8'h5C);
        chk("byp_b_other", rd_data_b, 8'hA1);
        rd_addr_b = 2'd2;
        step();
        chk("byp_b_same", rd_data_b, 8'h5C);
        chk("byp_count", wr_count, 5);

        // Illegal select 0110.
        wr_valid = 1'b1; wr_sel = 4'b0110; wr_data = 8'hFF;
        step();
        wr_valid = 1'b0;
        chk("ill_err", sel_err, 1);
        chk("ill_ready", wr_ready, 0);
        chk("ill_count", wr_count, 5);
        wr_valid = 1'b1; wr_sel = 4'b0001; wr_data = 8'h77;
        step();
        wr_valid = 1'b0;
        chk("err_ignore_count", wr_count, 5);
        chk("err_still", sel_err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_ready", wr_ready, 1);
        chk("clr_err", sel_err, 0);
        check_entries("clr_rd", 8'hA1, 8'hA2, 8'h5C, 8'hA4);

        // Illegal select 0000.
        wr_valid = 1'b1; wr_sel = 4'b0000; wr_data = 8'hFF;
        step();
        wr_valid = 1'b0;
        chk("zero_err", sel_err, 1);
        chk("zero_count", wr_count, 5);
        err_clr = 1'b1;
        step();
        chk("zero_clr", wr_ready, 1);
        step();
        err_clr = 1'b0;
        chk("idle_clr_noeffect", wr_ready, 1);
        check_entries("zero_rd", 8'hA1, 8'hA2, 8'h5C, 8'hA4);

        // Saturation: 260 more legal writes on top of 5.
        for (int i = 0; i < 260; i++) begin
            wr_valid = 1'b1;
            wr_sel   = 4'(1 << (i % 4));
            wr_data  = 8'(i);
            step();
            if (i == 99)  chk("sat_105", wr_count, 105);
            if (i == 249) chk("sat_255", wr_count, 255);
        end
        wr_valid = 1'b0;
        chk("sat_hold", wr_count, 255);
        // Last writes: i=256..259 -> entry0..3 data 00,01,02,03
        check_entries("sat_rd", 8'h00, 8'h01, 8'h02, 8'h03);

        // Reset colliding with a legal write to entry 3 read on port A.
        rd_addr_a = 2'd3; rd_addr_b = 2'd3;
        wr_valid = 1'b1; wr_sel = 4'b1000; wr_data = 8'h33; rst = 1'b1;
        step();
        rst = 1'b0; wr_valid = 1'b0;
        chk("rstwr_rd_a", rd_data_a, 0);
        chk("rstwr_count", wr_count, 0);
        chk("rstwr_ready", wr_ready, 1);
        check_entries("rstwr_rd", 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset while in ERROR.
        wr_valid = 1'b1; wr_sel = 4'b1100; wr_data = 8'h11;
        step();
        wr_valid = 1'b0;
        chk("rsterr_pre", sel_err, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rsterr_err", sel_err, 0);
        chk("rsterr_ready", wr_ready, 1);
        chk("rsterr_count", wr_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onehot_regbank.md
Name: onehot_regbank

Overview:
- Four-entry register bank that sits directly downstream of the 2-to-4 decoder.
- Consumes the decoder's one-hot select as its write enable and stores a WIDTH-bit word into the selected entry.
- Provides two registered read ports, a valid/ready write handshake, sticky detection of illegal (non-one-hot) selects, and a saturating count of completed writes.

Parameters:
- WIDTH, 8, data width of each entry and of the read/write data ports.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- wr_sel  input  4  one-hot entry select from the decoder; bit i selects entry i.
- wr_valid  input  1  write request.
- wr_data  input  WIDTH  write data.
- wr_ready  output  1  bank can accept a write this cycle.
- rd_addr_a  input  2  read port A address.
- rd_data_a  output  WIDTH  read port A data, one-cycle latency.
- rd_addr_b  input  2  read port B address.
- rd_data_b  output  WIDTH  read port B data, one-cycle latency.
- sel_err  output  1  high while in ERROR state.
- err_clr  input  1  leaves ERROR state.
- wr_count  output  8  number of completed writes, saturating.

Behaviour:
- Reset (rst high at a clk edge):
  - All four entries, rd_data_a, rd_data_b and wr_count go to 0.
  - State goes to IDLE, so wr_ready=1 and sel_err=0.
  - rst overrides every other input in the same cycle, including a handshake in flight.
- FSM states are IDLE and ERROR.
  - wr_ready = (state==IDLE).
  - sel_err = (state==ERROR).
- Handshake:
  - A write is accepted on a clk edge where wr_valid & wr_ready.
  - wr_data and wr_sel need only be stable in the accepting cycle.
- IDLE, accepted write, wr_sel exactly one-hot (0001, 0010, 0100 or 1000):
  - The selected entry takes wr_data at that edge.
  - wr_count increments by 1 and saturates at 255 (no wrap).
  - State stays IDLE, so back-to-back writes are accepted every cycle.
- IDLE, accepted write, wr_sel not one-hot (0000, or two or more bits set):
  - No entry is modified and wr_count is unchanged.
  - State goes to ERROR at that edge.
- IDLE, wr_valid low: no change.
- ERROR:
  - wr_ready=0, so no writes are accepted and wr_valid is ignored.
  - If err_clr=1 at a clk edge, state goes to IDLE and wr_ready=1 from the next cycle.
  - Entries and wr_count are preserved across ERROR.
  - err_clr in IDLE has no effect.
- Reads:
  - Each clk edge, rd_data_x is loaded from entry[rd_addr_x].
  - Both ports are independent and may address the same entry.
- Write-read bypass:
  - If a legal write is accepted at the same edge and targets entry rd_addr_x, rd_data_x is loaded with wr_data, not the old contents.
  - Read data is therefore never stale by one cycle.
- Entry index mapping: wr_sel bit i corresponds to rd_addr value i (bit0 is address 2'b00, bit3 is address 2'b11).
- No combinational path from any input to any output except state-derived wr_ready and sel_err, which are register outputs.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, then low; read all 4 addresses on both ports.
  - Required: rd_data=0 for every address, wr_ready=1, sel_err=0, wr_count=0.
- Legal writes:
  - Stimulus: write 8'hA1, A2, A3, A4 with wr_sel 0001, 0010, 0100, 1000 on consecutive cycles.
  - Required: all four accepted with no stall, wr_count=4, and reads of address 0..3 return A1..A4 one cycle after the address is applied.
- Bypass:
  - Stimulus: rd_addr_a=2 held; write 8'h5C with wr_sel 0100.
  - Required: rd_data_a=8'h5C on the cycle after the accepting edge.
  - Also: with rd_addr_b=2 and no write, port B returns the same value.
- Illegal select:
  - Stimulus: write 8'hFF with wr_sel 0110, then 0000 after recovery.
  - Required: no entry changes, wr_count unchanged, sel_err=1 and wr_ready=0 from the next cycle.
  - Required: a wr_valid pulse during ERROR is ignored.
  - Required: err_clr for 1 cycle leads to wr_ready=1 the following cycle, with entries intact.
- Count saturation:
  - Stimulus: 260 legal writes.
  - Required: wr_count reaches 255 and stays at 255.
- Reset mid-operation:
  - Stimulus: assert rst in the same cycle as an accepted legal write, and separately while in ERROR.
  - Required: the write does not land, all entries are 0, wr_count=0, and state is IDLE.
